fb_pixel_writer: RTL

Parametrised framebuffer pixel writer that sits between the line-drawing core and the framebuffer write port. It takes rasterised (x, y, steep, color) samples under a valid/ready handshake, undoes the octant swap, and clips against a configurable resolution. It then computes the linear framebuffer address through a 2-stage pipeline and buffers results in an output FIFO with backpressure. Saturating statistics counters report written and clipped pixels.

---
 rtl/fb_pixel_writer_if.sv | 28 ++
 rtl/fb_pixel_writer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer_if.sv
// Sample-in / pixel-out bus of the framebuffer pixel writer.
// The line core and framebuffer side use "master"; the writer uses "slave".
interface fb_pixel_writer_if #(
   parameter int WIDTH  = 13,
   parameter int ADDR_W = 19,
   parameter int COL_W  = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    steep;
   logic signed [WIDTH-1:0] x_coord;
   logic signed [WIDTH-1:0] y_coord;
   logic [COL_W-1:0]        color_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [ADDR_W-1:0]       FB_addr;
   logic [COL_W-1:0]        color_out;

   modport master (
      output in_valid, steep, x_coord, y_coord, color_in, out_ready,
      input  in_ready, out_valid, FB_addr, color_out
   );

   modport slave (
      input  in_valid, steep, x_coord, y_coord, color_in, out_ready,
      output in_ready, out_valid, FB_addr, color_out
   );
endinterface

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: octant unswap, clipping, 2-stage address pipeline,
// output FIFO with backpressure and saturating pixel / clip statistics.
module fb_pixel_writer #(
   parameter int WIDTH  = 13,
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int COL_W  = 3,
   parameter int DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   fb_pixel_writer_if.slave   bus,
   output logic [15:0]        pix_count,
   output logic [15:0]        clip_count,
   output logic               idle
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = PTR_W + 2;
   localparam int PW    = WIDTH + 33;
   localparam logic signed [WIDTH-1:0] H_LIM = WIDTH'(H_RES);
   localparam logic signed [WIDTH-1:0] V_LIM = WIDTH'(V_RES);

   logic                    s1_valid, s1_clip;
   logic signed [WIDTH-1:0] s1_px, s1_py;
   logic [COL_W-1:0]        s1_color;
   logic                    s2_valid, s2_clip;
   logic [ADDR_W-1:0]       s2_addr;
   logic [COL_W-1:0]        s2_color;

   logic [ADDR_W-1:0]       addr_mem  [DEPTH];
   logic [COL_W-1:0]        color_mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr, rd_next;
   logic [CNT_W-1:0]        fifo_count, cnt_next;
   logic [OCC_W-1:0]        occ;
   logic                    accept, push, pop;

   logic signed [WIDTH-1:0] px, py;
   logic                    clip;
   logic [ADDR_W-1:0]       addr_calc;
   logic [ADDR_W-1:0]       head_addr;
   logic [COL_W-1:0]        head_color;

   // Every in-flight sample already owns a FIFO slot, so the pipeline never stalls
   assign occ           = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
   assign bus.in_ready  = rst && (occ < OCC_W'(DEPTH));
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (fifo_count != '0);
   assign pop           = bus.out_valid && bus.out_ready;
   assign push          = s2_valid && !s2_clip;
   assign rd_next       = rd_ptr + PTR_W'(pop);
   assign cnt_next      = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign idle          = !s1_valid && !s2_valid && (fifo_count == '0);
   assign bus.FB_addr   = head_addr;
   assign bus.color_out = head_color;

   always_comb begin
      px   = bus.steep ? bus.y_coord : bus.x_coord;
      py   = bus.steep ? bus.x_coord : bus.y_coord;
      clip = px[WIDTH-1] || (px >= H_LIM) || py[WIDTH-1] || (py >= V_LIM);
      addr_calc = ADDR_W'(PW'(s1_py) * PW'(H_RES) + PW'(s1_px));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_px    <= px;
         s1_py    <= py;
         s1_color <= bus.color_in;
         s1_clip  <= clip;
      end
      s2_addr  <= addr_calc;
      s2_color <= s1_color;
      s2_clip  <= s1_clip;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr]  <= s2_addr;
         color_mem[wr_ptr] <= s2_color;
      end
   end

   // Head is registered so it can hold its last value (or 0 after reset) when empty
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         head_addr  <= '0;
         head_color <= '0;
         pix_count  <= '0;
         clip_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr     <= rd_next;
         fifo_count <= cnt_next;
         if (cnt_next != '0) begin
            if (push && (wr_ptr == rd_next)) begin
               head_addr  <= s2_addr;
               head_color <= s2_color;
            end else begin
               head_addr  <= addr_mem[rd_next];
               head_color <= color_mem[rd_next];
            end
         end
         if (pop && (pix_count != 16'hFFFF)) pix_count <= pix_count + 16'd1;
         if (s2_valid && s2_clip && (clip_count != 16'hFFFF)) clip_count <= clip_count + 16'd1;
      end
   end
endmodule
